data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter: HITCNT_ADDR, 32'h0000_3100, memory word address that receives the hit count after flush (see Configuration).
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 dmemREN  input  1  datapath load request.
REQ-005 dmemWEN  input  1  datapath store request.
REQ-006 dmemaddr  input  32  datapath word-aligned address.
REQ-007 dmemstore  input  32  store data.
REQ-008 halt  input  1  datapath halted; triggers flush.
REQ-009 dhit  output  1  request served this cycle.
REQ-010 dmemload  output  32  load data, valid while dhit=1.
REQ-011 flushed  output  1  flush complete; sticky until reset.
REQ-012 dREN  output  1  memory read request.
REQ-013 dWEN  output  1  memory write request.
REQ-014 daddr  output  32  memory address.
REQ-015 dstore  output  32  memory write data.
REQ-016 dload  input  32  memory read data.
REQ-017 dwait  input  1  memory busy; word transfer completes in the cycle dwait=0.

Function
REQ-018 The cache SHALL be direct-mapped, write-back, write-allocate: 16 sets, 2-word blocks; tag=addr[31:7], index=addr[6:3], word=addr[2], addr[1:0] ignored.
REQ-019 Hit (valid and tag match, state IDLE) SHALL assert dhit combinationally in the request cycle; a load drives dmemload from the array; a store writes the word at the clock edge and sets dirty.
REQ-020 dmemWEN SHALL take priority when dmemREN and dmemWEN are both 1.
REQ-021 FSM states: IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH, FWB0, FWB1, HITCNT, DONE.
REQ-022 Miss with dirty victim: IDLE->WB0->WB1->FETCH0->FETCH1->IDLE; clean or invalid victim: IDLE->FETCH0->FETCH1->IDLE; each WB/FETCH state advances only when dwait=0.
REQ-023 WBn SHALL drive dWEN=1, daddr={victim tag,index,n,2'b00}, dstore=victim word n; FETCHn SHALL drive dREN=1, daddr={req tag,index,n,2'b00} and capture dload on completion.
REQ-024 After FETCH1 the line SHALL be valid, clean, new tag; the retried request hits in IDLE on the following cycle (dhit is never asserted outside IDLE).
REQ-025 halt=1 in IDLE SHALL enter FLUSH; halt during a miss SHALL take effect only after return to IDLE.
REQ-026 FLUSH SHALL scan set index 0..15: a dirty set goes through FWB0->FWB1 (same addressing as WB), then valid and dirty cleared; a clean set costs one cycle; after set 15 go to HITCNT (or DONE).
REQ-027 DONE SHALL hold flushed=1, dREN=dWEN=0, ignore all requests, until reset.
REQ-028 The hit counter SHALL be 32 bits, increment once per dhit cycle, wrap at 2^32-1 -> 0.

Reset
REQ-029 nRST=0 SHALL asynchronously clear all valid/dirty bits, state->IDLE, counter->0, flush index->0; outputs dhit=0, dmemload=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0; data arrays need not reset.
REQ-030 Reset mid-miss or mid-flush SHALL abort the transfer with no further memory request.

Configuration
REQ-031 Macro DCACHE_HITCOUNT_EN defined: HITCNT state SHALL write the counter to HITCNT_ADDR (dWEN=1 until dwait=0) then enter DONE; undefined: FLUSH goes directly to DONE and the counter is not built.

Structure
REQ-032 State enum, tag/index/word field widths, set count and dcache frame struct (valid, dirty, tag, data[2]) SHALL live in cpu_types_pkg; no sub-module.

Verification
REQ-033 Cold load 0x40 with dwait=0 after 2 cycles per word -> FETCH0, FETCH1 at 0x40/0x44, then dhit=1, dmemload=mem[0x40].
REQ-034 Store 0xDEADBEEF to 0x40 (hit), then load 0x440 (same index 8) -> WB0/WB1 write 0xDEADBEEF to 0x40, fetch 0x440/0x444.
REQ-035 dmemREN=dmemWEN=1 to hit address 0x80 -> store performed, dirty set, dhit=1.
REQ-036 Three dirty sets, halt=1 -> exactly six memory writes in index order, flushed=1, then requests ignored.
REQ-037 With DCACHE_HITCOUNT_EN, 5 hits then halt -> final write 32'd5 to 0x3100; without macro, no write to 0x3100.
REQ-038 nRST pulse during FETCH1 -> dREN=0 immediately, state IDLE, next load to same address misses.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - data cache types: FSM states, address field widths, frame layout
package cpu_types_pkg;

    localparam int TAG_W = 25;
    localparam int IDX_W = 4;
    localparam int SETS  = 16;
    localparam int TAG_LSB  = 7;
    localparam int IDX_LSB  = 3;
    localparam int WORD_BIT = 2;

    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        FETCH0,
        FETCH1,
        FLUSH,
        FWB0,
        FWB1,
        HITCNT,
        DONE
    } dcache_state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
        logic [1:0][31:0] data;
    } dcache_frame_t;

    function automatic logic [31:0] block_addr(input logic [TAG_W-1:0] tag,
                                               input logic [IDX_W-1:0] idx,
                                               input logic             word);
        return {tag, idx, word, 2'b00};
    endfunction

endpackage

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back data cache, 16 x 2-word blocks, flush on halt
// Optional DCACHE_HITCOUNT_EN: after flush, write the hit count to HITCNT_ADDR.
module data_cache
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    dcache_state_t    state_q, state_d;
    dcache_frame_t    frames_q [SETS];
    dcache_frame_t    frames_d [SETS];
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
    logic [IDX_W-1:0] flush_idx_q, flush_idx_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             req_word;
    logic             xfer_word;
    logic             unused_inputs;

    assign req_tag  = dmemaddr[31:TAG_LSB];
    assign req_idx  = dmemaddr[TAG_LSB-1:IDX_LSB];
    assign req_word = dmemaddr[WORD_BIT];
    assign flushed  = (state_q == DONE);

`ifdef DCACHE_HITCOUNT_EN
    localparam dcache_state_t FLUSH_END = HITCNT;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    assign unused_inputs = ^dmemaddr[1:0];
`else
    localparam dcache_state_t FLUSH_END = DONE;
    assign unused_inputs = ^{HITCNT_ADDR, dmemaddr[1:0]};
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
            flush_idx_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                frames_q[i] <= '0;
            end
`ifdef DCACHE_HITCOUNT_EN
            hit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            miss_tag_q  <= miss_tag_d;
            miss_idx_q  <= miss_idx_d;
            flush_idx_q <= flush_idx_d;
            frames_q    <= frames_d;
`ifdef DCACHE_HITCOUNT_EN
            hit_cnt_q   <= hit_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        frames_d    = frames_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        flush_idx_d = flush_idx_q;
        dhit        = 1'b0;
        dmemload    = '0;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        daddr       = '0;
        dstore      = '0;
        // Second word of a block transfer is selected by the *1 states
        xfer_word   = (state_q == WB1) || (state_q == FETCH1) || (state_q == FWB1);
`ifdef DCACHE_HITCOUNT_EN
        hit_cnt_d   = hit_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d     = FLUSH;
                    flush_idx_d = '0;
                end else if (dmemREN || dmemWEN) begin
                    if (frames_q[req_idx].valid && (frames_q[req_idx].tag == req_tag)) begin
                        dhit = 1'b1;
                        if (dmemWEN) begin
                            frames_d[req_idx].data[req_word] = dmemstore;
                            frames_d[req_idx].dirty          = 1'b1;
                        end else begin
                            dmemload = frames_q[req_idx].data[req_word];
                        end
`ifdef DCACHE_HITCOUNT_EN
                        hit_cnt_d = hit_cnt_q + 32'd1;
`endif
                    end else begin
                        miss_tag_d = req_tag;
                        miss_idx_d = req_idx;
                        state_d    = (frames_q[req_idx].valid && frames_q[req_idx].dirty) ? WB0 : FETCH0;
                    end
                end
            end

            WB0, WB1: begin
                dWEN   = 1'b1;
                daddr  = block_addr(frames_q[miss_idx_q].tag, miss_idx_q, xfer_word);
                dstore = frames_q[miss_idx_q].data[xfer_word];
                if (!dwait) begin
                    state_d = xfer_word ? FETCH0 : WB1;
                end
            end

            FETCH0, FETCH1: begin
                dREN  = 1'b1;
                daddr = block_addr(miss_tag_q, miss_idx_q, xfer_word);
                if (!dwait) begin
                    frames_d[miss_idx_q].data[xfer_word] = dload;
                    if (xfer_word) begin
                        frames_d[miss_idx_q].valid = 1'b1;
                        frames_d[miss_idx_q].dirty = 1'b0;
                        frames_d[miss_idx_q].tag   = miss_tag_q;
                        state_d                    = IDLE;
                    end else begin
                        state_d = FETCH1;
                    end
                end
            end

            FLUSH: begin
                if (frames_q[flush_idx_q].valid && frames_q[flush_idx_q].dirty) begin
                    state_d = FWB0;
                end else if (flush_idx_q == LAST_SET) begin
                    state_d = FLUSH_END;
                end else begin
                    flush_idx_d = flush_idx_q + 4'd1;
                end
            end

            FWB0, FWB1: begin
                dWEN   = 1'b1;
                daddr  = block_addr(frames_q[flush_idx_q].tag, flush_idx_q, xfer_word);
                dstore = frames_q[flush_idx_q].data[xfer_word];
                if (!dwait) begin
                    if (!xfer_word) begin
                        state_d = FWB1;
                    end else begin
                        frames_d[flush_idx_q].valid = 1'b0;
                        frames_d[flush_idx_q].dirty = 1'b0;
                        if (flush_idx_q == LAST_SET) begin
                            state_d = FLUSH_END;
                        end else begin
                            flush_idx_d = flush_idx_q + 4'd1;
                            state_d     = FLUSH;
                        end
                    end
                end
            end

`ifdef DCACHE_HITCOUNT_EN
            HITCNT: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = hit_cnt_q;
                if (!dwait) begin
                    state_d = DONE;
                end
            end
`endif

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache with a 2-cycle-per-word memory model
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, halt;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;
    logic [31:0] dload;
    logic        dwait;

    data_cache #(.HITCNT_ADDR(32'h0000_3100)) dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];
    int          vec_cnt = 0;
    int          mis_cnt = 0;
    int          mcnt;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h5A5A_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory: each word completes on its second request cycle
    initial begin
        dwait = 1'b1;
        dload = '0;
        mcnt  = 0;
        forever begin
            @(negedge CLK);
            if (!dwait) mcnt = 0;
            if (nRST && (dREN || dWEN)) begin
                dload = mem_rd(daddr);
                if (mcnt >= 1) begin
                    dwait = 1'b0;
                    if (dWEN) begin
                        wr_addr_q.push_back(daddr);
                        wr_data_q.push_back(dstore);
                        mem[daddr] = dstore;
                    end else begin
                        rd_addr_q.push_back(daddr);
                    end
                end else begin
                    dwait = 1'b1;
                end
                mcnt++;
            end else begin
                dwait = 1'b1;
                mcnt  = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int cyc);
        dmemREN   = rd;
        dmemWEN   = wr;
        dmemaddr  = a;
        dmemstore = d;
        rdata     = '0;
        cyc       = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            #1;
            if (dhit) begin
                rdata = dmemload;
                cyc   = n;
                break;
            end
        end
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    logic [31:0] r;
    int          c;
    logic        found;
    logic [31:0] exp_a [6];
    logic [31:0] exp_d [6];
    int          exp_wr;

    initial begin
        nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
        dmemaddr = '0; dmemstore = '0;
        mem[32'h40]  = 32'h1111_0040; mem[32'h44]  = 32'h1111_0044;
        mem[32'h440] = 32'h2222_0440; mem[32'h444] = 32'h2222_0444;
        mem[32'h80]  = 32'h3333_0080; mem[32'h84]  = 32'h3333_0084;
        mem[32'h1C8] = 32'h4444_01C8; mem[32'h1CC] = 32'h4444_01CC;

        #12;
        chk("rst dhit", 32'(dhit), 32'd0);
        chk("rst dmemload", dmemload, 32'd0);
        chk("rst flushed", 32'(flushed), 32'd0);
        chk("rst dREN", 32'(dREN), 32'd0);
        chk("rst dWEN", 32'(dWEN), 32'd0);
        chk("rst daddr", daddr, 32'd0);
        chk("rst dstore", dstore, 32'd0);
        @(posedge CLK); #1; nRST = 1'b1;
        @(posedge CLK); #1;

        access(1'b1, 1'b0, 32'h40, 32'h0, r, c);
        chk("cold load cycles", 32'(c), 32'd5);
        chk("cold load data", r, 32'h1111_0040);
        chk("cold fetch count", 32'(rd_addr_q.size()), 32'd2);
        chk("cold fetch addr0", rd_addr_q[0], 32'h40);
        chk("cold fetch addr1", rd_addr_q[1], 32'h44);
        access(1'b1, 1'b0, 32'h44, 32'h0, r, c);
        chk("hit load 0x44 cycles", 32'(c), 32'd0);
        chk("hit load 0x44 data", r, 32'h1111_0044);

        access(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, r, c);
        chk("store hit cycles", 32'(c), 32'd0);
        rd_addr_q.delete();
        access(1'b1, 1'b0, 32'h440, 32'h0, r, c);
        chk("dirty miss cycles", 32'(c), 32'd9);
        chk("dirty miss data", r, 32'h2222_0440);
        chk("wb count", 32'(wr_addr_q.size()), 32'd2);
        chk("wb0 addr", wr_addr_q[0], 32'h40);
        chk("wb0 data", wr_data_q[0], 32'hDEAD_BEEF);
        chk("wb1 addr", wr_addr_q[1], 32'h44);
        chk("wb1 data", wr_data_q[1], 32'h1111_0044);
        chk("refill addr0", rd_addr_q[0], 32'h440);
        chk("refill addr1", rd_addr_q[1], 32'h444);

        access(1'b1, 1'b0, 32'h80, 32'h0, r, c);
        chk("load 0x80 cycles", 32'(c), 32'd5);
        chk("load 0x80 data", r, 32'h3333_0080);
        access(1'b1, 1'b1, 32'h80, 32'h0BAD_F00D, r, c);
        chk("ren+wen hit cycles", 32'(c), 32'd0);
        access(1'b1, 1'b0, 32'h80, 32'h0, r, c);
        chk("ren+wen stored data", r, 32'h0BAD_F00D);
        wr_addr_q.delete(); wr_data_q.delete();
        access(1'b1, 1'b0, 32'h880, 32'h0, r, c);
        chk("evict 0x80 cycles", 32'(c), 32'd9);
        chk("evict 0x80 wb addr", wr_addr_q[0], 32'h80);
        chk("evict 0x80 wb data", wr_data_q[0], 32'h0BAD_F00D);

        dmemREN = 1'b1; dmemaddr = 32'h1C8;
        found = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK); #1;
            if (dREN && daddr == 32'h1CC) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached FETCH1", 32'(found), 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid-fetch rst dREN", 32'(dREN), 32'd0);
        chk("mid-fetch rst daddr", daddr, 32'd0);
        chk("mid-fetch rst dhit", 32'(dhit), 32'd0);
        dmemREN = 1'b0;
        @(posedge CLK); #1; nRST = 1'b1;
        rd_addr_q.delete();
        repeat (3) @(posedge CLK);
        #1;
        chk("no request after rst", 32'(rd_addr_q.size()), 32'd0);
        access(1'b1, 1'b0, 32'h1C8, 32'h0, r, c);
        chk("post-rst load misses", 32'(c), 32'd5);
        chk("post-rst load data", r, 32'h4444_01C8);

        access(1'b0, 1'b1, 32'h1C8, 32'h9999_0001, r, c);
        chk("store 0x1C8 cycles", 32'(c), 32'd0);
        access(1'b0, 1'b1, 32'h10, 32'h5555_0002, r, c);
        chk("store-allocate 0x10 cycles", 32'(c), 32'd5);
        access(1'b0, 1'b1, 32'h3E8, 32'hCAFE_0013, r, c);
        chk("store-allocate 0x3E8 cycles", 32'(c), 32'd5);
        access(1'b1, 1'b0, 32'h1C8, 32'h0, r, c);
        chk("reload 0x1C8 data", r, 32'h9999_0001);

        wr_addr_q.delete(); wr_data_q.delete();
        exp_a = '{32'h10, 32'h14, 32'h1C8, 32'h1CC, 32'h3E8, 32'h3EC};
        exp_d = '{32'h5555_0002, 32'h5A5A_0014, 32'h9999_0001, 32'h4444_01CC, 32'hCAFE_0013, 32'h5A5A_03EC};
`ifdef DCACHE_HITCOUNT_EN
        exp_wr = 7;
`else
        exp_wr = 6;
`endif
        halt = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK); #1;
            if (flushed) begin
                found = 1'b1;
                break;
            end
        end
        chk("flushed", 32'(found), 32'd1);
        chk("flush write count", 32'(wr_addr_q.size()), 32'(exp_wr));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("flush wr%0d addr", i), wr_addr_q[i], exp_a[i]);
            chk($sformatf("flush wr%0d data", i), wr_data_q[i], exp_d[i]);
        end
`ifdef DCACHE_HITCOUNT_EN
        chk("hitcnt addr", wr_addr_q[6], 32'h0000_3100);
        chk("hitcnt data", wr_data_q[6], 32'd5);
`endif

        halt = 1'b0;
        dmemREN = 1'b1; dmemaddr = 32'h1C8;
        for (int n = 0; n < 4; n++) begin
            @(negedge CLK); #1;
            chk("done dhit", 32'(dhit), 32'd0);
            chk("done dREN", 32'(dREN | dWEN), 32'd0);
        end
        chk("done flushed sticky", 32'(flushed), 32'd1);
        chk("no writes after done", 32'(wr_addr_q.size()), 32'(exp_wr));
        dmemREN = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
